// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one single-port data RAM between the CPU MEM stage and the debug unit.
// Each access takes two cycles: an ISSUE cycle that drives the RAM port and a
// RESP cycle that returns the RAM read data together with a one-cycle ack.
// When both sides request at once, round-robin arbitration decides, so neither
// side can be starved.
//
// Parameters
//   len     data word width
//   ADDR_W  RAM word-address width
//
// Ports
//   clk, reset                    clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata         CPU access request (level, held until ack)
//   cpu_ack, cpu_rdata            CPU completion pulse and load data
//   cpu_stall                     pipeline freeze while a CPU access is pending
//   dbg_req/addr                  debug read request (level, held until ack)
//   dbg_ack, dbg_rdata            debug completion pulse and read data
//   ram_en/we/addr/din            RAM port controls
//   ram_dout                      RAM read data, one cycle after ram_en
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int unsigned len    = 32,
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [len-1:0]    cpu_wdata,
   output logic              cpu_ack,
   output logic [len-1:0]    cpu_rdata,
   output logic              cpu_stall,

   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_ack,
   output logic [len-1:0]    dbg_rdata,

   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [len-1:0]    ram_din,
   input  logic [len-1:0]    ram_dout
);

   // FSM state encoding
   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StIssueCpu = 3'd1;
   localparam logic [2:0] StRespCpu  = 3'd2;
   localparam logic [2:0] StIssueDbg = 3'd3;
   localparam logic [2:0] StRespDbg  = 3'd4;

   // last_grant encoding
   localparam logic GrantCpu = 1'b0;
   localparam logic GrantDbg = 1'b1;

   logic [2:0] state_q, state_d;
   logic       last_grant_q, last_grant_d;

   // ---------------------------------------------------------------------------
   // State registers. Reset leaves last_grant at DBG so the first tie goes to
   // the CPU.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= GrantDbg;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         StIdle: begin
            // CPU wins when it is alone, or on a tie if DBG was served last.
            if (cpu_req && (!dbg_req || (last_grant_q == GrantDbg))) begin
               state_d      = StIssueCpu;
               last_grant_d = GrantCpu;
            end else if (dbg_req) begin
               state_d      = StIssueDbg;
               last_grant_d = GrantDbg;
            end
         end
         StIssueCpu: state_d = StRespCpu;
         StIssueDbg: state_d = StRespDbg;
         StRespCpu: begin
            // cpu_req is still high this cycle for the access just acked, so
            // only the other side is looked at.
            if (dbg_req) begin
               state_d      = StIssueDbg;
               last_grant_d = GrantDbg;
            end else begin
               state_d = StIdle;
            end
         end
         StRespDbg: begin
            if (cpu_req) begin
               state_d      = StIssueCpu;
               last_grant_d = GrantCpu;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs are decoded straight from the state register, so an asynchronous
   // reset drops the RAM strobes and acks immediately. A store is only lost
   // if reset arrives before the edge that ends ISSUE_CPU.
   // ---------------------------------------------------------------------------
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
      cpu_ack   = 1'b0;
      cpu_rdata = '0;
      dbg_ack   = 1'b0;
      dbg_rdata = '0;
      case (state_q)
         StIssueCpu: begin
            ram_en   = 1'b1;
            ram_we   = cpu_we;
            ram_addr = cpu_addr;
            ram_din  = cpu_wdata;
         end
         StIssueDbg: begin
            // Debug port is read-only.
            ram_en   = 1'b1;
            ram_addr = dbg_addr;
         end
         StRespCpu: begin
            cpu_ack   = 1'b1;
            cpu_rdata = ram_dout;
         end
         StRespDbg: begin
            dbg_ack   = 1'b1;
            dbg_rdata = ram_dout;
         end
         default: ;
      endcase
   end

   assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus pushes expected acks into a
// queue, a negedge monitor pops and compares whenever an ack appears.
module tb_data_mem_arbiter;
   localparam int unsigned Len = 32;
   localparam int unsigned AW  = 11;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_wdata;
   logic          cpu_ack, cpu_stall;
   logic [31:0]   cpu_rdata;
   logic          dbg_req;
   logic [AW-1:0] dbg_addr;
   logic          dbg_ack;
   logic [31:0]   dbg_rdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic [31:0]   ram_dout;

   int errors = 0;
   int checks = 0;
   int we_cycles = 0;

   typedef struct packed {
      logic        who;   // 0 = CPU, 1 = DBG
      logic        care;  // compare data
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   data_mem_arbiter #(.len(Len), .ADDR_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .dbg_req   (dbg_req),
      .dbg_addr  (dbg_addr),
      .dbg_ack   (dbg_ack),
      .dbg_rdata (dbg_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   // RAM model with 1-cycle read latency plus a preload port.
   logic [31:0]   mem [0:2047];
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [31:0]   ld_data = '0;
   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         ram_dout <= mem[ram_addr];
      end
   end

   always @(negedge clk) if (ram_we) we_cycles <= we_cycles + 1;

   // Monitor
   always @(negedge clk) begin
      if (!reset && (cpu_ack || dbg_ack)) begin
         exp_t e;
         checks++;
         if (cpu_ack && dbg_ack) begin
            errors++;
            $display("FAIL ack_both: cpu_ack and dbg_ack high together");
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected: got ack cpu=%0b dbg=%0b, required none",
                     cpu_ack, dbg_ack);
         end else begin
            e = exp_q.pop_front();
            if (e.who != dbg_ack) begin
               errors++;
               $display("FAIL ack_order: got %s ack, required %s ack",
                        dbg_ack ? "DBG" : "CPU", e.who ? "DBG" : "CPU");
            end else if (e.care && ((dbg_ack ? dbg_rdata : cpu_rdata) !== e.data)) begin
               errors++;
               $display("FAIL ack_data: got %h, required %h",
                        dbg_ack ? dbg_rdata : cpu_rdata, e.data);
            end
         end
      end
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      ld_addr = a;
      ld_data = d;
      ld_en   = 1'b1;
      cyc();
      ld_en   = 1'b0;
   endtask

   task automatic push(input logic who, input logic care, input logic [31:0] d);
      exp_t e;
      e.who  = who;
      e.care = care;
      e.data = d;
      exp_q.push_back(e);
   endtask

   initial begin
      int we0;
      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_addr = '0;
      preload(11'd5, 32'hDEADBEEF);
      preload(11'd7, 32'h0);
      preload(11'd9, 32'h09090909);
      preload(11'h7FF, 32'hA5A50FF0);

      // Reset state
      smp();
      chk1("rst_ram_en", ram_en, 1'b0);
      chk1("rst_ram_we", ram_we, 1'b0);
      chk1("rst_cpu_ack", cpu_ack, 1'b0);
      chk1("rst_dbg_ack", dbg_ack, 1'b0);
      chk1("rst_stall", cpu_stall, 1'b0);
      cyc();
      reset = 1'b0;
      cyc();

      // CPU load of address 5
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd5;
      push(1'b0, 1'b1, 32'hDEADBEEF);
      smp();
      chk1("ld_c0_stall", cpu_stall, 1'b1);
      chk1("ld_c0_ram_en", ram_en, 1'b0);
      chk32("ld_c0_rdata", cpu_rdata, 32'h0);
      smp();
      chk1("ld_c1_ram_en", ram_en, 1'b1);
      chk32("ld_c1_ram_addr", 32'(ram_addr), 32'd5);
      chk1("ld_c1_ram_we", ram_we, 1'b0);
      chk1("ld_c1_stall", cpu_stall, 1'b1);
      smp();
      chk1("ld_c2_ack", cpu_ack, 1'b1);
      chk1("ld_c2_stall", cpu_stall, 1'b0);
      chk1("ld_c2_ram_en", ram_en, 1'b0);
      cyc();
      cpu_req = 1'b0;
      cyc();

      // CPU store 0x12345678 to address 7
      we0 = we_cycles;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd7; cpu_wdata = 32'h12345678;
      push(1'b0, 1'b0, 32'h0);
      smp();
      smp();
      chk1("st_c1_ram_we", ram_we, 1'b1);
      chk32("st_c1_ram_addr", 32'(ram_addr), 32'd7);
      chk32("st_c1_ram_din", ram_din, 32'h12345678);
      smp();
      chk1("st_c2_ack", cpu_ack, 1'b1);
      cyc();
      cpu_req = 1'b0; cpu_we = 1'b0;
      cyc();
      chk32("st_we_cycles", 32'(we_cycles - we0), 32'd1);

      // Debug read of address 7 returns the stored word
      dbg_req = 1'b1; dbg_addr = 11'd7;
      push(1'b1, 1'b1, 32'h12345678);
      smp();
      smp();
      chk1("dr7_c1_ram_en", ram_en, 1'b1);
      chk1("dr7_c1_ram_we", ram_we, 1'b0);
      smp();
      chk1("dr7_c2_ack", dbg_ack, 1'b1);
      cyc();
      dbg_req = 1'b0;
      cyc();

      // Debug read of the top address
      dbg_req = 1'b1; dbg_addr = 11'h7FF;
      push(1'b1, 1'b1, 32'hA5A50FF0);
      smp();
      smp();
      chk32("drtop_c1_ram_addr", 32'(ram_addr), 32'h7FF);
      chk1("drtop_c1_ram_we", ram_we, 1'b0);
      smp();
      chk1("drtop_c2_ack", dbg_ack, 1'b1);
      chk1("drtop_c2_cpu_ack", cpu_ack, 1'b0);
      cyc();
      dbg_req = 1'b0;
      cyc();

      // Reset during ISSUE_CPU of a store drops the write
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd9; cpu_wdata = 32'hBAD0BAD0;
      smp();
      smp();
      chk1("strst_c1_ram_we", ram_we, 1'b1);
      #1 reset = 1'b1;
      #1;
      chk1("strst_async_we", ram_we, 1'b0);
      chk1("strst_async_en", ram_en, 1'b0);
      cyc();
      cpu_req = 1'b0; cpu_we = 1'b0;
      cyc();
      reset = 1'b0;
      cyc();
      dbg_req = 1'b1; dbg_addr = 11'd9;
      push(1'b1, 1'b1, 32'h09090909);
      smp();
      smp();
      smp();
      chk1("strst_rd_ack", dbg_ack, 1'b1);
      cyc();
      dbg_req = 1'b0;
      cyc();

      // Fresh reset, then both requesting continuously: CPU, DBG, CPU, DBG
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd5;
      dbg_req = 1'b1; dbg_addr = 11'd7;
      push(1'b0, 1'b1, 32'hDEADBEEF);
      push(1'b1, 1'b1, 32'h12345678);
      push(1'b0, 1'b1, 32'hDEADBEEF);
      push(1'b1, 1'b1, 32'h12345678);
      for (int c = 0; c <= 8; c++) begin
         logic ec, ed;
         smp();
         ec = (c == 2) || (c == 6);
         ed = (c == 4) || (c == 8);
         chk1($sformatf("rr_c%0d_cpu_ack", c), cpu_ack, ec);
         chk1($sformatf("rr_c%0d_dbg_ack", c), dbg_ack, ed);
         chk1($sformatf("rr_c%0d_stall", c), cpu_stall, cpu_req && !ec);
         cyc();
         if (c == 6) cpu_req = 1'b0;
         if (c == 8) dbg_req = 1'b0;
      end
      cyc();

      // Reset during RESP_DBG: ack falls at once, next tie goes to CPU
      dbg_req = 1'b1; dbg_addr = 11'h7FF;
      push(1'b1, 1'b1, 32'hA5A50FF0);
      smp();
      smp();
      smp();
      chk1("rrst_c2_ack", dbg_ack, 1'b1);
      #1 reset = 1'b1;
      #1;
      chk1("rrst_async_ack", dbg_ack, 1'b0);
      chk32("rrst_async_rdata", dbg_rdata, 32'h0);
      cyc();
      dbg_req = 1'b0;
      cyc();
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd5;
      dbg_req = 1'b1; dbg_addr = 11'd7;
      push(1'b0, 1'b1, 32'hDEADBEEF);
      push(1'b1, 1'b1, 32'h12345678);
      smp();
      smp();
      chk32("rrst_tie_addr", 32'(ram_addr), 32'd5);
      smp();
      chk1("rrst_tie_cpu_ack", cpu_ack, 1'b1);
      cyc();
      cpu_req = 1'b0;
      smp();
      smp();
      chk1("rrst_tie_dbg_ack", dbg_ack, 1'b1);
      cyc();
      dbg_req = 1'b0;
      cyc();

      // CPU arrives while DBG is in ISSUE_DBG
      dbg_req = 1'b1; dbg_addr = 11'h7FF;
      push(1'b1, 1'b1, 32'hA5A50FF0);
      push(1'b0, 1'b1, 32'hDEADBEEF);
      smp();
      cyc();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd5;
      smp();
      chk1("late_c1_stall", cpu_stall, 1'b1);
      chk32("late_c1_addr", 32'(ram_addr), 32'h7FF);
      smp();
      chk1("late_c2_dbg_ack", dbg_ack, 1'b1);
      chk1("late_c2_stall", cpu_stall, 1'b1);
      cyc();
      dbg_req = 1'b0;
      smp();
      chk1("late_c3_ram_en", ram_en, 1'b1);
      chk32("late_c3_addr", 32'(ram_addr), 32'd5);
      chk1("late_c3_stall", cpu_stall, 1'b1);
      smp();
      chk1("late_c4_cpu_ack", cpu_ack, 1'b1);
      chk1("late_c4_stall", cpu_stall, 1'b0);
      cyc();
      cpu_req = 1'b0;
      cyc();
      cyc();

      chk32("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter len, default 32: data word width.
REQ-002 Parameter ADDR_W, default 11: data RAM word-address width (2048-word RAM).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cpu_req  in  1  MEM-stage access request, level; held with cpu_we/cpu_addr/cpu_wdata stable until cpu_ack.
REQ-006 cpu_we  in  1  1 = store, 0 = load.
REQ-007 cpu_addr  in  ADDR_W  CPU word address.
REQ-008 cpu_wdata  in  len  CPU store data (already byte/half formatted upstream).
REQ-009 cpu_ack  out  1  one-cycle completion pulse for the CPU access.
REQ-010 cpu_rdata  out  len  load data; valid only while cpu_ack=1.
REQ-011 cpu_stall  out  1  pipeline freeze request.
REQ-012 dbg_req  in  1  debug-unit read request, level; held with dbg_addr stable until dbg_ack.
REQ-013 dbg_addr  in  ADDR_W  debug word address.
REQ-014 dbg_ack  out  1  one-cycle completion pulse for the debug read.
REQ-015 dbg_rdata  out  len  debug read data; valid only while dbg_ack=1.
REQ-016 ram_en  out  1  RAM port enable.
REQ-017 ram_we  out  1  RAM write enable.
REQ-018 ram_addr  out  ADDR_W  RAM address.
REQ-019 ram_din  out  len  RAM write data.
REQ-020 ram_dout  in  len  RAM read data, valid the cycle after ram_en=1 (1-cycle latency).

Function
REQ-021 FSM states: IDLE, ISSUE_CPU, RESP_CPU, ISSUE_DBG, RESP_DBG; encoding free.
REQ-022 One-bit register last_grant (CPU/DBG) records the requester most recently moved to ISSUE_*.
REQ-023 Arbitration (IDLE): only cpu_req -> ISSUE_CPU; only dbg_req -> ISSUE_DBG; both -> the requester not equal to last_grant (round-robin); none -> stay IDLE.
REQ-024 ISSUE_x: ram_en=1, ram_addr=x address, ram_we=cpu_we in ISSUE_CPU and 0 in ISSUE_DBG, ram_din=cpu_wdata in ISSUE_CPU, 0 otherwise; next state RESP_x unconditionally.
REQ-025 RESP_x: x_ack=1, x_rdata=ram_dout, ram_en=0, ram_we=0.
REQ-026 RESP_x next state: other requester's req high -> ISSUE_other; otherwise IDLE; the just-acked requester's req is ignored this cycle.
REQ-027 Outside ISSUE_*: ram_en=0, ram_we=0, ram_addr=0, ram_din=0; outside RESP_x: x_ack=0, x_rdata=0.
REQ-028 cpu_stall = cpu_req AND NOT cpu_ack (combinational); cpu_stall=0 whenever cpu_req=0.
REQ-029 Access latency: grant in IDLE at cycle N -> ISSUE at N+1 -> ack at N+2; back-to-back alternating accesses complete every 2 cycles.
REQ-030 Worst-case wait: a continuously requesting side is granted within one foreign access (no starvation).
REQ-031 Stores are acked identically to loads; cpu_rdata content during a store ack is don't-care.
REQ-032 Request dropped during ISSUE/RESP (protocol violation): access completes, ack still pulses once.
REQ-033 Exactly one of ISSUE_CPU/ISSUE_DBG drives the RAM at a time; ram_we never asserted in ISSUE_DBG.

Reset
REQ-034 reset=1 forces immediately, regardless of clock: state=IDLE, last_grant=DBG, all registered outputs 0; ram_en, ram_we, cpu_ack, dbg_ack are 0.
REQ-035 Reset mid-access abandons the access with no ack; a store in ISSUE_CPU is dropped only if reset asserts before the edge ending ISSUE_CPU.
REQ-036 First arbitration after reset with both requesting grants CPU.

Verification
REQ-037 CPU load only: cpu_req=1, cpu_we=0, cpu_addr=5, RAM[5]=0xDEADBEEF -> ram_en at cycle 1, cpu_ack with cpu_rdata=0xDEADBEEF at cycle 2, cpu_stall=1 at cycles 0-1 and 0 at cycle 2.
REQ-038 CPU store: cpu_we=1, cpu_addr=7, cpu_wdata=0x12345678 -> ram_we=1, ram_addr=7, ram_din=0x12345678 for exactly one cycle; a later dbg read of 7 returns 0x12345678.
REQ-039 Simultaneous requests after reset, both held continuously -> grant order CPU, DBG, CPU, DBG; acks alternate every 2 cycles.
REQ-040 Debug read only, dbg_addr=0x7FF -> ram_we never 1, dbg_ack with RAM[0x7FF] two cycles after request, cpu_ack stays 0.
REQ-041 Reset asserted during RESP_DBG -> dbg_ack falls asynchronously, state IDLE, next tie grants CPU.
REQ-042 CPU requests while DBG in ISSUE_DBG -> cpu_stall held high, CPU issued in the cycle after dbg_ack, cpu_ack one cycle later.
